load_store_unit: RTL and testbench

//  Core-side requester for data_mem: accepts one load/store per handshake from the EX/MEM stage.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the data_mem port of the load/store unit.
// The slave modport is the LSU; the master is the EX/MEM stage together with data_mem.
interface load_store_unit_if #(
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [2:0]                req_funct3;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;

    logic                      resp_valid;
    logic [31:0]               resp_rdata;
    logic                      resp_err;

    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_wr_en;
    logic [31:0]               mem_wr_data;
    logic [31:0]               mem_rd_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Core-side load/store requester for a word-wide data_mem with combinational read.
// Sub-word stores are done as read-modify-write; one request outstanding at a time.
module load_store_unit #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;

    logic                      r_we;
    logic [2:0]                r_funct3;
    logic [MEM_ADDR_WIDTH-1:0] r_wordAddr;
    logic [1:0]                r_byteOff;
    logic [31:0]               r_wdata;
    logic [31:0]               r_merged;
    logic [31:0]               r_rdata;
    logic                      r_err;

    logic                      w_accept;
    logic                      w_illegal;
    logic                      w_misaligned;
    logic                      w_reqErr;
    logic [31:0]               w_loadData;
    logic [31:0]               w_mergedWord;
    logic                      w_unusedAddrBits;

    assign w_unusedAddrBits = ^bus.req_addr[31:MEM_ADDR_WIDTH+2];

    function automatic logic [31:0] extractLoad(
        input logic [2:0]  funct3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Only the addressed lane(s) take store data; the rest keep the word just read.
    function automatic logic [31:0] mergeStore(
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic [31:0] word,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        res = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (off[1]) begin
                res[31:16] = wdata[15:0];
            end else begin
                res[15:0] = wdata[15:0];
            end
        end
        return res;
    endfunction

    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'b000:  w_misaligned = 1'b0;
                3'b001:  w_misaligned = bus.req_addr[0];
                3'b010:  w_misaligned = |bus.req_addr[1:0];
                default: w_illegal    = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b100: w_misaligned = 1'b0;
                3'b001, 3'b101: w_misaligned = bus.req_addr[0];
                3'b010:         w_misaligned = |bus.req_addr[1:0];
                default:        w_illegal    = 1'b1;
            endcase
        end
        w_reqErr = w_illegal | w_misaligned;
    end

    assign w_accept     = rst_n && (r_state == IDLE) && bus.req_valid;
    assign w_loadData   = extractLoad(r_funct3, r_byteOff, bus.mem_rd_data);
    assign w_mergedWord = mergeStore(r_funct3[1:0], r_byteOff, bus.mem_rd_data, r_wdata);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_wordAddr <= '0;
            r_byteOff  <= 2'd0;
            r_wdata    <= 32'd0;
            r_merged   <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_funct3   <= bus.req_funct3;
                        r_wordAddr <= bus.req_addr[MEM_ADDR_WIDTH+1:2];
                        r_byteOff  <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        r_rdata    <= 32'd0;
                        r_err      <= w_reqErr;
                    end
                end
                RD: begin
                    if (r_we) begin
                        r_merged <= w_mergedWord;
                    end else begin
                        r_rdata <= w_loadData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every output is forced low while rst_n is low, so an interrupted WR cannot write.
    always_comb begin
        w_nextState     = r_state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = 32'd0;
        bus.resp_err    = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 32'd0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (w_accept) begin
                        if (w_reqErr) begin
                            w_nextState = RESP;
                        end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                            w_nextState = WR;
                        end else begin
                            w_nextState = RD;
                        end
                    end
                end
                RD: begin
                    bus.mem_addr = r_wordAddr;
                    w_nextState  = r_we ? WR : RESP;
                end
                WR: begin
                    bus.mem_addr    = r_wordAddr;
                    bus.mem_wr_en   = 1'b1;
                    bus.mem_wr_data = (r_funct3[1:0] == 2'b10) ? r_wdata : r_merged;
                    w_nextState     = RESP;
                end
                RESP: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = r_rdata;
                    bus.resp_err   = r_err;
                    w_nextState    = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference model predicts each response,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_load_store_unit;

    localparam int AW = 10;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] dmem   [0:1023];
    logic [31:0] refMem [0:1023];

    exp_t expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   acceptCyc = 0;
    int   wrCount   = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.MEM_ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // data_mem stand-in: combinational read, write on posedge.
    assign bus.mem_rd_data = dmem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            dmem[bus.mem_addr] <= bus.mem_wr_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-offset arithmetic on a word array.
    function automatic exp_t modelAccess(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         input string name);
        exp_t        e;
        int          off;
        int          widx;
        int          size;
        bit          bad;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        off  = int'(addr % 4);
        widx = int'((addr / 4) % 1024);
        if (we) begin
            bad  = (f3 > 3'd2);
            size = 1 << (int'(f3) % 4);
        end else begin
            bad  = (f3 == 3'd3) || (f3 >= 3'd6);
            size = 1 << (int'(f3) % 4);
        end
        if (!bad && (off % size) != 0) bad = 1'b1;
        e.err    = bad;
        e.rdata  = 32'd0;
        e.writes = 0;
        e.name   = name;
        e.lat    = 1;
        if (!bad) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            word = refMem[widx];
            if (!we) begin
                val = (word >> (8 * off)) & mask;
                if (f3 < 3'd4 && size < 4 && val[8 * size - 1]) val = val | ~mask;
                e.rdata = val;
                e.lat   = 2;
            end else begin
                refMem[widx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
                e.lat    = (size == 4) ? 2 : 3;
                e.writes = 1;
            end
        end
        return e;
    endfunction

    // Call #1 after a posedge; returns #1 after the accepting posedge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold, input string name);
        int waitCnt;
        waitCnt        = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        while (!bus.req_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_accept_timeout actual=req_ready 0 required=req_ready 1", name);
            bus.req_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        expQ.push_back(modelAccess(we, f3, addr, wdata, name));
        if (!hold) begin
            bus.req_valid  = 1'b0;
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.req_valid && bus.req_ready) acceptCyc = cyc + 1;
        if (bus.mem_wr_en) wrCount++;
        if (bus.resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_resp actual=resp_valid 1 required=no response pending");
            end else begin
                e = expQ.pop_front();
                checkOutput({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                checkOutput({e.name, "_err"}, 32'(bus.resp_err), 32'(e.err));
                checkOutput({e.name, "_latency"}, 32'((cyc + 1) - acceptCyc), 32'(e.lat));
                checkOutput({e.name, "_writes"}, 32'(wrCount), 32'(e.writes));
            end
            wrCount = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] tmp;
        int          drain;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            tmp       = $urandom;
            dmem[i]   <= tmp;
            refMem[i] = tmp;
        end
        dmem[2]   <= 32'h1122_3344;
        refMem[2] = 32'h1122_3344;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_wr_data", bus.mem_wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset while the SB to 0x08 sits in WR must leave data_mem untouched.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h08;
        bus.req_wdata  = 32'h0000_005A;
        @(negedge clk);
        checkOutput("rstop_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstop_wr_en", 32'(bus.mem_wr_en), 32'd0);
        checkOutput("rstop_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rstop_ready_after", 32'(bus.req_ready), 32'd1);
        checkOutput("rstop_mem", dmem[2], refMem[2]);
        wrCount = 0;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, "sw_10");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw_10");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1'b0, "sw_base_b");
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h0000_00A5, 1'b0, "sb_13");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw_after_sb");
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, "lb_13");
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, "lbu_13");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1'b0, "sw_base_h");
        applyStimulus(1'b1, 3'b001, 32'h12, 32'h0000_8001, 1'b0, "sh_12");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw_after_sh");
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, "lh_12");
        applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, "lhu_12");

        applyStimulus(1'b0, 3'b010, 32'h06, 32'h0, 1'b0, "err_lw_06");
        applyStimulus(1'b1, 3'b001, 32'h05, 32'hFFFF_FFFF, 1'b0, "err_sh_05");
        applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 1'b0, "err_ld_f3_011");
        applyStimulus(1'b1, 3'b101, 32'h24, 32'h1234_5678, 1'b0, "err_st_f3_101");

        applyStimulus(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 1'b1, "b2b_sw_40");
        applyStimulus(1'b0, 3'b000, 32'h41, 32'h0, 1'b1, "b2b_lb_41");
        applyStimulus(1'b1, 3'b001, 32'h42, 32'hABCD_1234, 1'b0, "b2b_sh_42");
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, "b2b_lw_40");

        for (int n = 0; n < 80; n++) begin
            applyStimulus(1'($urandom), 3'($urandom), $urandom_range(0, 127), $urandom,
                          1'($urandom), $sformatf("rnd%0d", n));
        end
        bus.req_valid = 1'b0;

        drain = 0;
        while (expQ.size() != 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        #1;
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
        @(negedge clk);
        for (int w = 0; w < 32; w++) begin
            checkOutput($sformatf("mem_w%0d", w), dmem[w], refMem[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
